fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: word address of the first fetch after reset.
REQ-002 SHALL have parameter FETCH_LAT, default 1, legal range 1-15: cycles spent in FETCH before imem_data is sampled.
REQ-003 SHALL have parameter NOOP_HALT_COUNT, default 2, legal range 1-15: number of consecutive accepted all-zero (NOOP) instructions that triggers halt.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 imem_addr  output  32  word address driven to the instruction memory PC input.
REQ-007 imem_data  input  32  instruction word returned by the instruction memory for imem_addr.
REQ-008 instr  output  32  registered instruction held for the consumer.
REQ-009 instr_pc  output  32  word address from which instr was fetched.
REQ-010 instr_valid  output  1  instr and instr_pc are valid.
REQ-011 instr_ready  input  1  consumer accepts instr in the current cycle.
REQ-012 redirect_valid  input  1  branch/jump taken; load the PC from redirect_target.
REQ-013 redirect_target  input  32  absolute word address of the next fetch.
REQ-014 halted  output  1  sequencer stopped.
REQ-015 accept_count  output  16  number of instructions accepted since reset; saturates at 0xFFFF.

Function
REQ-016 SHALL implement exactly three states: FETCH, HOLD and HALT.
REQ-017 SHALL drive imem_addr from an internal pc register at all times.
REQ-018 FETCH: a latency counter lat_cnt SHALL start at 0 and increment once per cycle.
REQ-019 FETCH, when lat_cnt == FETCH_LAT-1: SHALL capture instr<=imem_data and instr_pc<=pc, then go to HOLD; instr_valid=1 from the following cycle.
REQ-020 HOLD: SHALL keep instr, instr_pc and instr_valid=1 stable until instr_ready=1.
REQ-021 HOLD with instr_ready=1 is an accept, and SHALL:
  - increment accept_count;
  - update the NOOP counter: nop_cnt+1 if instr==0, else reset to 0.
REQ-022 On an accept without redirect, when the updated nop_cnt == NOOP_HALT_COUNT, SHALL go to HALT.
REQ-023 On any other accept without redirect, SHALL:
  - set pc<=pc+1 with 32-bit wrap (0xFFFFFFFF -> 0);
  - clear lat_cnt;
  - go to FETCH, with instr_valid=0 next cycle.
REQ-024 redirect_valid=1 in FETCH or HOLD SHALL set pc<=redirect_target, clear lat_cnt and nop_cnt, and go to FETCH with instr_valid=0 next cycle.
REQ-025 A redirect in HOLD without instr_ready SHALL discard the held instruction, with no accept counted.
REQ-026 redirect_valid and instr_ready both 1 in HOLD:
  - the accept SHALL be counted in accept_count;
  - the redirect SHALL win the PC;
  - no halt SHALL occur in that cycle.
REQ-027 A redirect in FETCH SHALL abort the pending capture, so the old address is never presented as instr.
REQ-028 HALT SHALL be absorbing until reset:
  - halted=1 and instr_valid=0;
  - pc holds the address of the last accepted instruction;
  - redirect_valid and instr_ready are ignored.
REQ-029 Throughput: with FETCH_LAT=1 and instr_ready held at 1, SHALL achieve one accept every 2 cycles.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force, on the next cycle:
  - state=FETCH, pc=RESET_PC, lat_cnt=0, nop_cnt=0;
  - instr=0, instr_pc=0, instr_valid=0;
  - halted=0, accept_count=0.
REQ-031 Reset SHALL take priority over redirect, accept and halt, including mid-FETCH, mid-HOLD and in HALT.

Verification
REQ-032 Reset release, FETCH_LAT=1, memory returns 0xE400FFFF at address 0, ready=1 -> instr_valid at cycle 2 with instr=0xE400FFFF and instr_pc=0; imem_addr=1 in the cycle after the accept.
REQ-033 J at address 18, consumer asserts redirect_valid with target 21 together with ready -> accept_count+1; next instr_pc=21; addresses 19 and 20 never appear as instr_pc.
REQ-034 Backpressure: ready=0 for 5 cycles in HOLD -> instr, instr_pc and imem_addr stable; accept_count unchanged.
REQ-035 NOOP at addresses 22 and 23, NOOP_HALT_COUNT=2 -> halted=1 after the second accept; instr_valid=0; imem_addr=23; a later redirect has no effect.
REQ-036 FETCH_LAT=3 with redirect in the second FETCH cycle -> no capture; three further FETCH cycles at the target; capture in the third.
REQ-037 rst_n=0 while in HALT with accept_count=0x0010 -> all outputs at REQ-030 values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: instruction-memory port plus the consumer-side handshake.
// master = sequencer, slave = memory/consumer.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic [15:0] accept_count;

  modport master (
    output imem_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    output halted,
    output accept_count,
    input  imem_data,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    input  imem_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  halted,
    input  accept_count,
    output imem_data,
    output instr_ready,
    output redirect_valid,
    output redirect_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fixed-latency fetch, held hand-off to a consumer,
// redirects, and a halt after a run of consecutive all-zero instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter int unsigned FETCH_LAT       = 1,
  parameter int unsigned NOOP_HALT_COUNT = 2
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;

  localparam logic [3:0] LatLast = 4'(FETCH_LAT - 1);
  localparam logic [3:0] NopHalt = 4'(NOOP_HALT_COUNT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  nop_q, nop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  nop_upd;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      lat_q      <= 4'd0;
      nop_q      <= 4'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      acc_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lat_q      <= lat_d;
      nop_q      <= nop_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      acc_q      <= acc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lat_d      = lat_q;
    nop_d      = nop_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    acc_d      = acc_q;
    nop_upd    = (instr_q == 32'd0) ? nop_q + 4'd1 : 4'd0;

    unique case (state_q)
      StFetch: begin
        if (bus.redirect_valid) begin
          // Abort the pending capture; the old address never reaches instr.
          pc_d    = bus.redirect_target;
          lat_d   = 4'd0;
          nop_d   = 4'd0;
          state_d = StFetch;
        end else if (lat_q == LatLast) begin
          instr_d    = bus.imem_data;
          instr_pc_d = pc_q;
          state_d    = StHold;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      StHold: begin
        if (bus.instr_ready && (acc_q != 16'hFFFF)) begin
          acc_d = acc_q + 16'd1;
        end
        if (bus.redirect_valid) begin
          // Redirect wins the PC and suppresses any halt, even alongside an accept.
          pc_d    = bus.redirect_target;
          lat_d   = 4'd0;
          nop_d   = 4'd0;
          state_d = StFetch;
        end else if (bus.instr_ready) begin
          nop_d = nop_upd;
          if (nop_upd == NopHalt) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 32'd1;
            lat_d   = 4'd0;
            state_d = StFetch;
          end
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.imem_addr    = pc_q;
    bus.instr        = instr_q;
    bus.instr_pc     = instr_pc_q;
    bus.instr_valid  = (state_q == StHold);
    bus.halted       = (state_q == StHalt);
    bus.accept_count = acc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scoreboarded accepts on a FETCH_LAT=1 instance plus
// directed redirect-abort checks on a FETCH_LAT=3 instance.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_nb;

  fetch_sequencer_if ifa ();
  fetch_sequencer_if ifb ();

  fetch_sequencer #(
    .RESET_PC       (32'd0),
    .FETCH_LAT      (1),
    .NOOP_HALT_COUNT(2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  fetch_sequencer #(
    .RESET_PC       (32'd5),
    .FETCH_LAT      (3),
    .NOOP_HALT_COUNT(2)
  ) u_dut_lat3 (
    .clk  (clk),
    .rst_n(rst_nb),
    .bus  (ifb)
  );

  logic [31:0] mem [64];
  assign ifa.imem_data = mem[ifa.imem_addr[5:0]];
  assign ifb.imem_data = mem[ifb.imem_addr[5:0]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   acc_cyc [64];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_b = 1'b0;

  logic [31:0] exp_pc;
  logic [3:0]  exp_nop;
  logic [15:0] exp_acc;
  logic        exp_halt;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 | 32'(i);
      acc_cyc[i] = -1;
    end
    mem[0]  = 32'hE400_FFFF;
    mem[18] = 32'h0000_006F;
    mem[22] = 32'd0;
    mem[23] = 32'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accept seen on the bus is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ifa.instr_valid && ifa.instr_ready) begin
        acc_cyc[ifa.instr_pc[5:0]] = cyc;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got accept at pc %h, expected none", ifa.instr_pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr_pc", ifa.instr_pc, e.pc);
          check("sb_instr", ifa.instr, e.data);
        end
      end
    end
  end

  task automatic model_reset();
    exp_pc   = 32'd0;
    exp_nop  = 4'd0;
    exp_acc  = 16'd0;
    exp_halt = 1'b0;
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!ifa.instr_valid && waited < 40);
    check("instr_valid_seen", 32'(ifa.instr_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, ifa.imem_addr, 32'd0);
    check({tag, "_instr"}, ifa.instr, 32'd0);
    check({tag, "_instr_pc"}, ifa.instr_pc, 32'd0);
    check({tag, "_instr_valid"}, 32'(ifa.instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(ifa.halted), 32'd0);
    check({tag, "_accept_count"}, 32'(ifa.accept_count), 32'd0);
  endtask

  // Wait for the held instruction, optionally stall, then accept (with optional redirect).
  task automatic accept_one(input logic redir, input logic [31:0] tgt, input int hold,
                            output int waited);
    exp_t        e;
    logic [31:0] h_instr, h_pc, h_addr;
    logic [15:0] h_acc;
    logic [31:0] data;
    wait_valid(waited);
    data   = mem[exp_pc[5:0]];
    e.pc   = exp_pc;
    e.data = data;
    sb_q.push_back(e);
    h_instr = ifa.instr;
    h_pc    = ifa.instr_pc;
    h_addr  = ifa.imem_addr;
    h_acc   = ifa.accept_count;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("stall_instr", ifa.instr, h_instr);
      check("stall_instr_pc", ifa.instr_pc, h_pc);
      check("stall_imem_addr", ifa.imem_addr, h_addr);
      check("stall_accept_count", 32'(ifa.accept_count), 32'(h_acc));
      check("stall_valid", 32'(ifa.instr_valid), 32'd1);
    end
    ifa.instr_ready     = 1'b1;
    ifa.redirect_valid  = redir;
    ifa.redirect_target = tgt;
    @(posedge clk);
    #1;
    ifa.instr_ready    = 1'b0;
    ifa.redirect_valid = 1'b0;
    exp_acc = exp_acc + 16'd1;
    if (redir) begin
      exp_nop = 4'd0;
      exp_pc  = tgt;
    end else begin
      exp_nop = (data == 32'd0) ? exp_nop + 4'd1 : 4'd0;
      if (exp_nop == 4'd2) exp_halt = 1'b1;
      else exp_pc = exp_pc + 32'd1;
    end
    check("accept_count", 32'(ifa.accept_count), 32'(exp_acc));
    check("halted", 32'(ifa.halted), 32'(exp_halt));
    check("imem_addr_after_accept", ifa.imem_addr, exp_pc);
    check("valid_after_accept", 32'(ifa.instr_valid), 32'd0);
  endtask

  // Redirect while holding, without accepting: the held instruction is dropped.
  task automatic discard(input logic [31:0] tgt);
    int w;
    wait_valid(w);
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = tgt;
    @(posedge clk);
    #1;
    ifa.redirect_valid = 1'b0;
    exp_pc  = tgt;
    exp_nop = 4'd0;
    check("discard_accept_count", 32'(ifa.accept_count), 32'(exp_acc));
    check("discard_imem_addr", ifa.imem_addr, tgt);
    check("discard_valid", 32'(ifa.instr_valid), 32'd0);
  endtask

  initial begin
    int w;
    int b_wait;
    rst_n               = 1'b0;
    ifa.instr_ready     = 1'b0;
    ifa.redirect_valid  = 1'b0;
    ifa.redirect_target = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    accept_one(1'b0, 32'd0, 0, w);
    check("first_valid_latency", 32'(w), 32'd1);
    accept_one(1'b1, 32'd12, 0, w);
    for (int i = 12; i < 18; i++) accept_one(1'b0, 32'd0, 0, w);
    check("throughput_12_to_17", 32'(acc_cyc[17] - acc_cyc[12]), 32'd10);

    accept_one(1'b1, 32'd21, 0, w);
    discard(32'd40);
    accept_one(1'b0, 32'd0, 5, w);
    accept_one(1'b1, 32'd21, 0, w);
    check("pc19_never_accepted", 32'(acc_cyc[19]), 32'hFFFF_FFFF);
    check("pc20_never_accepted", 32'(acc_cyc[20]), 32'hFFFF_FFFF);
    accept_one(1'b0, 32'd0, 0, w);
    accept_one(1'b0, 32'd0, 0, w);
    accept_one(1'b1, 32'd22, 0, w);
    check("no_halt_on_redirect", 32'(ifa.halted), 32'd0);
    accept_one(1'b0, 32'd0, 0, w);
    accept_one(1'b0, 32'd0, 0, w);

    check("halt_accept_count", 32'(ifa.accept_count), 32'h10);
    ifa.instr_ready     = 1'b1;
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("halt_sticky", 32'(ifa.halted), 32'd1);
      check("halt_valid", 32'(ifa.instr_valid), 32'd0);
      check("halt_imem_addr", ifa.imem_addr, 32'd23);
      check("halt_accept_count_hold", 32'(ifa.accept_count), 32'h10);
    end
    ifa.instr_ready    = 1'b0;
    ifa.redirect_valid = 1'b0;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("halt_reset");
    rst_n = 1'b1;
    model_reset();
    accept_one(1'b0, 32'd0, 0, w);
    check("restart_latency", 32'(w), 32'd1);

    b_wait = 0;
    while (!done_b && b_wait < 100) begin
      @(posedge clk);
      b_wait++;
    end
    check("lat3_done", 32'(done_b), 32'd1);
    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // FETCH_LAT=3 instance: redirect during the second FETCH cycle.
  initial begin
    rst_nb              = 1'b0;
    ifb.instr_ready     = 1'b0;
    ifb.redirect_valid  = 1'b0;
    ifb.redirect_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("b_reset_imem_addr", ifb.imem_addr, 32'd5);
    check("b_reset_valid", 32'(ifb.instr_valid), 32'd0);
    rst_nb = 1'b1;
    @(posedge clk);
    #1;
    check("b_fetch1_valid", 32'(ifb.instr_valid), 32'd0);
    ifb.redirect_valid  = 1'b1;
    ifb.redirect_target = 32'd50;
    @(posedge clk);
    #1;
    ifb.redirect_valid = 1'b0;
    check("b_redirect_imem_addr", ifb.imem_addr, 32'd50);
    check("b_redirect_valid", 32'(ifb.instr_valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("b_fetch_progress_valid", 32'(ifb.instr_valid), 32'(k == 3));
    end
    check("b_instr_pc", ifb.instr_pc, 32'd50);
    check("b_instr", ifb.instr, mem[50]);
    ifb.instr_ready = 1'b1;
    @(posedge clk);
    #1;
    ifb.instr_ready = 1'b0;
    check("b_accept_count", 32'(ifb.accept_count), 32'd1);
    check("b_next_imem_addr", ifb.imem_addr, 32'd51);
    done_b = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
